// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM / I/O arbiter.
// Port A is the CPU, port B the DMA/video fetch.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM,
        ST_RELEASE,
        ST_IO,
        ST_DONE
    } state_e;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hC000;
    localparam logic [15:0] IO_TIMEOUT_DATA = 16'hFFFF;
    localparam logic        OWNER_A         = 1'b0;
    localparam logic        OWNER_B         = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-input round-robin grant with a last-grant register and a per-input eligibility mask.
// The grant is combinational; last_grant advances only when update is high and a grant is made.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic elig_a,
    input  logic elig_b,
    input  logic update,
    output logic gnt_valid,
    output logic gnt_owner
);

    logic last_q;
    logic last_d;
    logic cand_a;
    logic cand_b;

    always_comb begin
        cand_a    = req_a & elig_a;
        cand_b    = req_b & elig_b;
        gnt_valid = cand_a | cand_b;
        // On a tie the side that did not win last time goes first.
        if (cand_a && cand_b) begin
            gnt_owner = (last_q == OWNER_A) ? OWNER_B : OWNER_A;
        end else begin
            gnt_owner = cand_b ? OWNER_B : OWNER_A;
        end
        last_d = (update && gnt_valid) ? gnt_owner : last_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= OWNER_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SRAM controller port between CPU (A) and DMA (B) and routes the top
// address window to a separate I/O bus with a bounded wait for io_ready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 3,
    parameter logic [15:0] IO_BASE       = IO_BASE_DEFAULT,
    parameter int unsigned IO_TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_we,
    input  logic        b_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] b_addr,
    input  logic [15:0] a_wdata,
    input  logic [15:0] b_wdata,
    output logic [15:0] a_rdata,
    output logic [15:0] b_rdata,
    output logic        a_ack,
    output logic        b_ack,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic        io_sel,
    output logic        io_we,
    output logic [13:0] io_addr,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    input  logic        io_ready,
    output logic        busy,
    output logic        owner
);

    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    localparam int TW = $clog2(IO_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(IO_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          owner_q, owner_d;
    logic [15:0]   a_rdata_q, a_rdata_d;
    logic [15:0]   b_rdata_q, b_rdata_d;
    logic          a_acked_q, b_acked_q;
    logic          gnt_valid, gnt_owner;
    logic [15:0]   sel_addr;
    logic          cap_en;
    logic [15:0]   cap_data;

    // A requester acked last cycle sits out one IDLE cycle so it cannot hog the port.
    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (a_req),
        .req_b    (b_req),
        .elig_a   (!a_acked_q),
        .elig_b   (!b_acked_q),
        .update   (state_q == ST_IDLE),
        .gnt_valid(gnt_valid),
        .gnt_owner(gnt_owner)
    );

    assign sel_addr = (gnt_owner == OWNER_B) ? b_addr : a_addr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        owner_d   = owner_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        cap_en    = 1'b0;
        cap_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_owner;
                    addr_d  = sel_addr;
                    we_d    = (gnt_owner == OWNER_B) ? b_we : a_we;
                    wdata_d = (gnt_owner == OWNER_B) ? b_wdata : a_wdata;
                    cnt_d   = CNT_LOAD;
                    tmo_d   = '0;
                    state_d = (sel_addr < IO_BASE) ? ST_MEM : ST_IO;
                end
            end
            ST_MEM: begin
                if (cnt_q == '0) begin
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            // Enables are low here so the controller's byte phase restarts for the next word.
            ST_RELEASE: begin
                cap_en   = !we_q;
                cap_data = mem_data_out;
                state_d  = ST_DONE;
            end
            ST_IO: begin
                if (io_ready) begin
                    cap_en   = !we_q;
                    cap_data = io_rdata;
                    state_d  = ST_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    cap_en   = !we_q;
                    cap_data = IO_TIMEOUT_DATA;
                    state_d  = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (cap_en) begin
            if (owner_q == OWNER_B) begin
                b_rdata_d = cap_data;
            end else begin
                a_rdata_d = cap_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            owner_q   <= OWNER_A;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_acked_q <= 1'b0;
            b_acked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            owner_q   <= owner_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            a_acked_q <= a_ack;
            b_acked_q <= b_ack;
        end
    end

    assign mem_address  = addr_q;
    assign mem_data_in  = wdata_q;
    assign mem_read_en  = (state_q == ST_MEM) && !we_q;
    assign mem_write_en = (state_q == ST_MEM) && we_q;
    assign io_sel       = (state_q == ST_IO);
    assign io_we        = (state_q == ST_IO) && we_q;
    assign io_addr      = addr_q[13:0];
    assign io_wdata     = wdata_q;
    assign a_ack        = (state_q == ST_DONE) && (owner_q == OWNER_A);
    assign b_ack        = (state_q == ST_DONE) && (owner_q == OWNER_B);
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign busy         = (state_q != ST_IDLE);
    assign owner        = owner_q;

endmodule
